// File: rtl/gmii_tx_ifg_arbiter.sv
// gmii_tx_ifg_arbiter: round-robin two-source GMII TX arbiter with inter-frame gap and runaway-frame truncation.
// Defining TX_ARB_STATS_EN adds per-source frame counters and a truncation counter.
module gmii_tx_ifg_arbiter #(
    parameter int IFG_BYTES       = 12,
    parameter int GRANT_TIMEOUT   = 64,
    parameter int MAX_FRAME_BYTES = 1534
) (
    input  logic        gmii_tx_clk,
    input  logic        rst,
    input  logic        s0_req,
    output logic        s0_gnt,
    input  logic [7:0]  s0_txd,
    input  logic        s0_txen,
    input  logic        s1_req,
    output logic        s1_gnt,
    input  logic [7:0]  s1_txd,
    input  logic        s1_txen,
    output logic [7:0]  gmii_txd,
    output logic        gmii_txen,
    output logic        gmii_txer,
    output logic        busy,
    output logic        frame_done,
`ifdef TX_ARB_STATS_EN
    output logic [15:0] s0_frame_cnt,
    output logic [15:0] s1_frame_cnt,
    output logic [15:0] trunc_cnt,
`endif
    output logic        trunc_err
);
    typedef enum logic [2:0] {IDLE, GRANT_WAIT, PASS, DRAIN, IFG} state_t;
    state_t      state;
    logic        cur, last_served, pick, sel_txen;
    logic [7:0]  sel_txd, wait_cnt, ifg_cnt;
    logic [10:0] byte_cnt;
    assign sel_txen = cur ? s1_txen : s0_txen;
    assign sel_txd  = cur ? s1_txd : s0_txd;
    assign pick     = (s0_req && s1_req) ? !last_served : s1_req;
    assign busy     = state != IDLE;
    always_ff @(posedge gmii_tx_clk) begin
        if (rst) begin
            state       <= IDLE;
            cur         <= 1'b0;
            last_served <= 1'b0;
            s0_gnt      <= 1'b0;
            s1_gnt      <= 1'b0;
            gmii_txd    <= '0;
            gmii_txen   <= 1'b0;
            gmii_txer   <= 1'b0;
            frame_done  <= 1'b0;
            trunc_err   <= 1'b0;
            wait_cnt    <= '0;
            ifg_cnt     <= '0;
            byte_cnt    <= '0;
        end else begin
            frame_done <= 1'b0;
            trunc_err  <= 1'b0;
            gmii_txer  <= 1'b0;
            case (state)
                IDLE: if (s0_req || s1_req) begin
                    cur      <= pick;
                    s0_gnt   <= !pick;
                    s1_gnt   <= pick;
                    wait_cnt <= '0;
                    state    <= GRANT_WAIT;
                end
                GRANT_WAIT: if (sel_txen) begin
                    gmii_txd  <= sel_txd;
                    gmii_txen <= 1'b1;
                    byte_cnt  <= 11'd1;
                    state     <= PASS;
                end else if (wait_cnt == 8'(GRANT_TIMEOUT - 1)) begin
                    s0_gnt      <= 1'b0;
                    s1_gnt      <= 1'b0;
                    last_served <= cur;
                    state       <= IDLE;
                end else begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
                PASS: if (!sel_txen) begin
                    gmii_txd    <= '0;
                    gmii_txen   <= 1'b0;
                    frame_done  <= 1'b1;
                    s0_gnt      <= 1'b0;
                    s1_gnt      <= 1'b0;
                    last_served <= cur;
                    ifg_cnt     <= 8'(IFG_BYTES);
                    state       <= IFG;
                end else begin
                    gmii_txd  <= sel_txd;
                    gmii_txen <= 1'b1;
                    byte_cnt  <= byte_cnt + 11'd1;
                    // the byte that reaches the limit still goes out, flagged as errored
                    if (byte_cnt == 11'(MAX_FRAME_BYTES - 1)) begin
                        gmii_txer   <= 1'b1;
                        trunc_err   <= 1'b1;
                        s0_gnt      <= 1'b0;
                        s1_gnt      <= 1'b0;
                        last_served <= cur;
                        state       <= DRAIN;
                    end
                end
                DRAIN: begin
                    gmii_txd  <= '0;
                    gmii_txen <= 1'b0;
                    if (!sel_txen) begin
                        ifg_cnt <= 8'(IFG_BYTES);
                        state   <= IFG;
                    end
                end
                IFG: if (ifg_cnt == 8'd0) state <= IDLE;
                     else ifg_cnt <= ifg_cnt - 8'd1;
                default: state <= IDLE;
            endcase
        end
    end
`ifdef TX_ARB_STATS_EN
    // last_served already names the source whose frame_done is pulsing
    always_ff @(posedge gmii_tx_clk) begin
        if (rst) begin
            s0_frame_cnt <= '0;
            s1_frame_cnt <= '0;
            trunc_cnt    <= '0;
        end else begin
            if (frame_done && !last_served) s0_frame_cnt <= s0_frame_cnt + 16'd1;
            if (frame_done && last_served) s1_frame_cnt <= s1_frame_cnt + 16'd1;
            if (trunc_err) trunc_cnt <= trunc_cnt + 16'd1;
        end
    end
`endif
endmodule
